// File: rtl/paint_pkg.sv
// paint_pkg: shared types for the cursor-point to frame-store brush path.
// Point coordinates are carried at PT_COORD_W bits inside point_t.
package paint_pkg;

    localparam int PT_COORD_W = 8;

    // 3-bit palette code; code 0 is black.
    typedef logic [2:0] color_t;

    localparam color_t ERASE_COLOR = 3'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STAMP = 2'd2
    } stamp_state_t;

    typedef struct packed {
        logic [PT_COORD_W-1:0] x;
        logic [PT_COORD_W-1:0] y;
        color_t                color;
        logic                  erase;
    } point_t;

    // Color actually written for a point: erase overrides the requested color.
    function automatic color_t stamp_color(input point_t p);
        return p.erase ? ERASE_COLOR : p.color;
    endfunction

endpackage

// File: rtl/stamp_fifo.sv
// stamp_fifo: small synchronous point FIFO with full/empty flags.
// Push and pop in the same cycle are both honoured. The head is read
// combinationally so the consumer can latch it in the cycle it pops.
module stamp_fifo
    import paint_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  point_t push_data,
    input  logic   pop,
    output point_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    point_t      mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Entry storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/brush_stamp_engine.sv
// brush_stamp_engine: queues cursor points and expands each into a
// (2R+1)x(2R+1) brush stamp, clipped to the canvas, written one pixel per
// cycle to the frame store. Define ROUND_BRUSH_EN to skip offsets outside
// the rounded brush (dx*dx+dy*dy > R*R+R); otherwise the full square is used.
module brush_stamp_engine
    import paint_pkg::*;
#(
    parameter int COORD_W    = PT_COORD_W,
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119,
    parameter int RADIUS     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    input  color_t             pt_color,
    input  logic               pt_erase,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output color_t             wr_color,
    output logic               busy
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [3:0]    R_POS = 4'(RADIUS);
    localparam logic signed [3:0]    R_NEG = -R_POS;
    localparam logic signed [SW-1:0] X_LIM = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_LIM = SW'(Y_MAX);

    stamp_state_t         state_reg;
    stamp_state_t         state_next;
    point_t               push_data;
    point_t               fifo_head;
    point_t               work_reg;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic signed [3:0]    dx_reg;
    logic signed [3:0]    dy_reg;
    logic signed [SW-1:0] px;
    logic signed [SW-1:0] py;
    logic                 in_canvas;
    logic                 in_brush;
    logic                 pix_on;
    logic                 out_stall;
    logic                 issue;
    logic                 last_off;
    logic                 wr_en_reg;
    logic [COORD_W-1:0]   wr_x_reg;
    logic [COORD_W-1:0]   wr_y_reg;
    color_t               wr_color_reg;

    assign push_data = '{x: pt_x, y: pt_y, color: pt_color, erase: pt_erase};
    assign fifo_push = pt_valid && !fifo_full;
    assign pt_ready  = !fifo_full;

    stamp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pixel address of the current offset, signed so left/top clipping is a sign test.
    assign px = $signed({2'b00, work_reg.x}) + {{(SW-4){dx_reg[3]}}, dx_reg};
    assign py = $signed({2'b00, work_reg.y}) + {{(SW-4){dy_reg[3]}}, dy_reg};
    assign in_canvas = !px[SW-1] && (px <= X_LIM) && !py[SW-1] && (py <= Y_LIM);

`ifdef ROUND_BRUSH_EN
    localparam logic signed [7:0] R2_LIM = 8'(RADIUS * RADIUS + RADIUS);
    logic signed [7:0] dx_w;
    logic signed [7:0] dy_w;
    logic signed [7:0] dist2;
    assign dx_w     = {{4{dx_reg[3]}}, dx_reg};
    assign dy_w     = {{4{dy_reg[3]}}, dy_reg};
    assign dist2    = dx_w * dx_w + dy_w * dy_w;
    assign in_brush = (dist2 <= R2_LIM);
`else
    assign in_brush = 1'b1;
`endif

    assign pix_on    = in_canvas && in_brush;
    // A presented pixel the frame store has not taken blocks the scan.
    assign out_stall = wr_en_reg && !wr_ready;
    assign issue     = (state_reg == STAMP) && !out_stall;
    assign last_off  = (dx_reg == R_POS) && (dy_reg == R_POS);

    // Next-state logic; LOAD is the only state that pops the FIFO.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                fifo_pop   = 1'b1;
                state_next = STAMP;
            end
            STAMP: begin
                if (issue && last_off) begin
                    state_next = fifo_empty ? IDLE : LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Working point and row-major offset scan (dx inner, dy outer).
    always_ff @(posedge clk) begin
        if (reset) begin
            work_reg <= '0;
            dx_reg   <= '0;
            dy_reg   <= '0;
        end else if (state_reg == LOAD) begin
            work_reg <= fifo_head;
            dx_reg   <= R_NEG;
            dy_reg   <= R_NEG;
        end else if (issue) begin
            if (dx_reg == R_POS) begin
                dx_reg <= R_NEG;
                dy_reg <= dy_reg + 4'sd1;
            end else begin
                dx_reg <= dx_reg + 4'sd1;
            end
        end
    end

    // Registered write port; held while the frame store stalls, cleared once drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_reg    <= 1'b0;
            wr_x_reg     <= '0;
            wr_y_reg     <= '0;
            wr_color_reg <= '0;
        end else if (issue) begin
            wr_en_reg <= pix_on;
            if (pix_on) begin
                wr_x_reg     <= px[COORD_W-1:0];
                wr_y_reg     <= py[COORD_W-1:0];
                wr_color_reg <= stamp_color(work_reg);
            end
        end else if (wr_ready) begin
            wr_en_reg <= 1'b0;
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_x     = wr_x_reg;
    assign wr_y     = wr_y_reg;
    assign wr_color = wr_color_reg;
    assign busy     = !fifo_empty || (state_reg != IDLE) || wr_en_reg;

endmodule

// File: tb/tb_brush_stamp_engine.sv
// tb_brush_stamp_engine: directed and randomized checks of the brush stamp
// engine against a per-point pixel list computed from the brush rules.
module tb_brush_stamp_engine;
    import paint_pkg::*;

    localparam int CW = 8;
    localparam int XM = 159;
    localparam int YM = 119;
    localparam int FD = 4;
`ifdef ROUND_BRUSH_EN
    localparam int R = 2;
`else
    localparam int R = 1;
`endif

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          pt_valid = 1'b0;
    logic          pt_ready;
    logic [CW-1:0] pt_x     = '0;
    logic [CW-1:0] pt_y     = '0;
    logic [2:0]    pt_color = '0;
    logic          pt_erase = 1'b0;
    logic          wr_en;
    logic          wr_ready = 1'b1;
    logic [CW-1:0] wr_x;
    logic [CW-1:0] wr_y;
    logic [2:0]    wr_color;
    logic          busy;

    int total = 0;
    int bad   = 0;
    bit rand_ready = 1'b0;
    int exp_q[$];
    int got_q[$];

    always #5 clk = ~clk;

    brush_stamp_engine #(
        .COORD_W    (CW),
        .X_MAX      (XM),
        .Y_MAX      (YM),
        .RADIUS     (R),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_x     (pt_x),
        .pt_y     (pt_y),
        .pt_color (pt_color),
        .pt_erase (pt_erase),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_color (wr_color),
        .busy     (busy)
    );

    function automatic int enc(input int x, input int y, input int c);
        return (x << 16) | (y << 8) | c;
    endfunction

    // Reference: every pixel a point should produce, in scan order.
    function automatic void model_point(input int x, input int y, input int c, input bit er);
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                int px;
                int py;
                px = x + dx;
                py = y + dy;
                if (px < 0 || px > XM || py < 0 || py > YM) continue;
`ifdef ROUND_BRUSH_EN
                if (dx * dx + dy * dy > R * R + R) continue;
`endif
                exp_q.push_back(enc(px, py, er ? int'(ERASE_COLOR) : c));
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: checks stall stability, logs frame-store writes, optionally randomizes wr_ready.
    task automatic tick();
        logic [19:0] pre;
        bit          stalled;
        bit          wrote;
        pre     = {wr_en, wr_x, wr_y, wr_color};
        stalled = (wr_en === 1'b1) && (wr_ready === 1'b0) && (reset === 1'b0);
        wrote   = (wr_en === 1'b1) && (wr_ready === 1'b1) && (reset === 1'b0);
        if (wrote) got_q.push_back(enc(int'(wr_x), int'(wr_y), int'(wr_color)));
        @(posedge clk);
        #1;
        if (stalled) chk("stall_hold", {12'd0, wr_en, wr_x, wr_y, wr_color}, {12'd0, pre});
        if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_point(input int x, input int y, input int c, input bit e,
                              input int max_wait, output bit ok);
        pt_x     = CW'(x);
        pt_y     = CW'(y);
        pt_color = 3'(c);
        pt_erase = e;
        pt_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            if (pt_ready === 1'b1) begin
                ok = 1'b1;
                model_point(x, y, c, e);
            end
            tick();
        end
        pt_valid = 1'b0;
    endtask

    task automatic push_must(input int x, input int y, input int c, input bit e);
        bit ok;
        push_point(x, y, c, e, 300, ok);
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        rand_ready = 1'b0;
        wr_ready   = 1'b1;
        tick();
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_pix"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int acc;
        int n;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_x", 32'(wr_x), 32'd0);
        chk("rst_wr_y", 32'(wr_y), 32'd0);
        chk("rst_wr_color", 32'(wr_color), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pt_ready", 32'(pt_ready), 32'd1);
        reset = 1'b0;
        tick();
        chk("post_rst_pt_ready", 32'(pt_ready), 32'd1);

        // 1: single point, latency and one pixel per cycle
`ifndef ROUND_BRUSH_EN
        push_must(10, 20, 3, 1'b0);
        chk("lat_t0", 32'(wr_en), 32'd0);
        tick();
        chk("lat_t1", 32'(wr_en), 32'd0);
        tick();
        chk("lat_t2", 32'(wr_en), 32'd0);
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("run_wr_en", 32'(wr_en), 32'd1);
            tick();
        end
        chk("run_end_wr_en", 32'(wr_en), 32'd0);
`else
        push_must(10, 20, 3, 1'b0);
`endif
        wait_idle("t1", 100);
        check_stream("t1");

        // 2: canvas corners
        push_must(0, 0, 6, 1'b0);
        wait_idle("t2a", 100);
        check_stream("t2a");
        push_must(XM, YM, 2, 1'b0);
        wait_idle("t2b", 100);
        check_stream("t2b");

        // 3: capacity with the frame store stalled
        wr_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            push_point(int'($urandom_range(0, XM)), int'($urandom_range(0, YM)),
                       int'($urandom_range(0, 7)), 1'b0, 4, ok);
            if (ok) acc++;
        end
        chk("cap_accepted", acc, FD + 1);
        chk("cap_ready_low", 32'(pt_ready), 32'd0);
        repeat (5) tick();
        chk("cap_busy", 32'(busy), 32'd1);
        wr_ready = 1'b1;
        wait_idle("t3", 400);
        check_stream("t3");

        // 4: random wr_ready during stamps, including edge points
        rand_ready = 1'b1;
        push_must(0, YM, 1, 1'b0);
        push_must(XM, 0, 7, 1'b0);
        for (int k = 0; k < 6; k++) begin
            push_must(int'($urandom_range(0, XM)), int'($urandom_range(0, YM)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        wait_idle("t4", 3000);
        check_stream("t4");

        // 5: erase overrides color
        push_must(40, 60, 5, 1'b1);
        wait_idle("t5", 100);
        check_stream("t5");
`ifdef ROUND_BRUSH_EN
        push_must(50, 50, 4, 1'b0);
        wait_idle("t5r", 100);
        chk("round_count", got_q.size(), 32'd21);
        n = 0;
        foreach (got_q[i]) begin
            if ((got_q[i] >> 8) == ((48 << 8) | 48) || (got_q[i] >> 8) == ((52 << 8) | 52)) n++;
        end
        chk("round_corners", n, 32'd0);
        check_stream("t5r");
`endif

        // 6: reset on the 4th write with two points queued
        push_must(30, 30, 1, 1'b0);
        push_must(31, 31, 2, 1'b0);
        push_must(32, 32, 3, 1'b0);
        n = 0;
        while (!(wr_en === 1'b1 && got_q.size() == 3) && n < 40) begin
            tick();
            n++;
        end
        chk("rst_reach_4th", 32'(n < 40), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pt_ready", 32'(pt_ready), 32'd1);
        chk("mid_rst_wr_x", 32'(wr_x), 32'd0);
        reset = 1'b0;
        repeat (30) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        check_stream("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
